mobo_responder: RTL

Target-side endpoint of the motherboard bus driven by the CPU: it samples the CPU's control word, address and write data, performs a single-word read or write on an internal memory array after a configurable number of wait states, and reports progress on the status word. One transaction is outstanding at a time. It sits on the mobo side of the CPU's `addr_out`/`mobodat_out`/`mobodat_in`/`mobo_ctrl`/`mobo_stat` signals and is the memory model/controller those signals talk to.

---
 rtl/mobo_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mobo_responder.sv
// mobo_responder: target-side endpoint of the motherboard bus.
// The block latches one CPU request (read or write) and waits LATENCY extra
// cycles. It then accesses the internal word array and reports progress on
// mobo_stat. The block holds DONE until the initiator returns to CTRL_NONE.
//
// Optional build macro:
//   MOBO_RESP_ADDR_CHECK_EN - reject addresses with bits set at or above
//                             log2(MEM_DEPTH). Timing is unchanged, but DONE
//                             reports MOBO_ERR and no access is made.
//                             Without it, the address wraps modulo MEM_DEPTH.
//
// state | meaning
// IDLE  | waiting for CTRL_READ / CTRL_WRITE
// BUSY  | request latched, wait counter running, access on counter == 0
// DONE  | result valid on mobo_stat / data_out, waiting for CTRL_NONE
module mobo_responder #(
    parameter int word_width = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] mobo_ctrl,
    output logic [word_width-1:0] mobo_stat,
    input  logic [word_width-1:0] addr_in,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [word_width-1:0] CTRL_READ  = word_width'(1);
    localparam logic [word_width-1:0] CTRL_WRITE = word_width'(2);

    localparam logic [word_width-1:0] STAT_IDLE = word_width'(0);
    localparam logic [word_width-1:0] STAT_BUSY = word_width'(1);
    localparam logic [word_width-1:0] STAT_DONE = word_width'(2);
    localparam logic [word_width-1:0] STAT_ERR  = word_width'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [word_width-1:0]   stat_q;
    logic [word_width-1:0]   data_out_q;
    logic [3:0]              cnt_q;
    logic                    op_wr_q;
    logic [AW-1:0]           idx_q;
    logic [word_width-1:0]   wdata_q;
    logic                    err_q;

    logic [word_width-1:0]   mem_q [MEM_DEPTH];

    logic                    req_rd;
    logic                    req_wr;
    logic                    addr_err;
    logic                    mem_we;

    assign req_rd = (mobo_ctrl == CTRL_READ);
    assign req_wr = (mobo_ctrl == CTRL_WRITE);

`ifdef MOBO_RESP_ADDR_CHECK_EN
    assign addr_err = |addr_in[word_width-1:AW];
`else
    // Upper address bits deliberately play no part when wrapping.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_in[word_width-1:AW];
    assign addr_err       = 1'b0;
`endif

    // Writes commit only on the access edge. Reset on that same edge suppresses the write.
    assign mem_we = rst && (state_q == ST_BUSY) && (cnt_q == 4'd0) && op_wr_q && !err_q;

    // Request sequencing: latch, count wait states, access, then hold the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stat_q     <= STAT_IDLE;
            data_out_q <= '0;
            cnt_q      <= 4'd0;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_rd || req_wr) begin
                        op_wr_q <= req_wr;
                        idx_q   <= addr_in[AW-1:0];
                        wdata_q <= data_in;
                        err_q   <= addr_err;
                        cnt_q   <= 4'(LATENCY);
                        state_q <= ST_BUSY;
                        stat_q  <= STAT_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        if (!op_wr_q && !err_q) begin
                            data_out_q <= mem_q[idx_q];
                        end
                        state_q <= ST_DONE;
                        stat_q  <= err_q ? STAT_ERR : STAT_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!(req_rd || req_wr)) begin
                        state_q <= ST_IDLE;
                        stat_q  <= STAT_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    stat_q  <= STAT_IDLE;
                end
            endcase
        end
    end

    // Word array. It is not cleared by reset, so contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mobo_stat = stat_q;
    assign data_out  = data_out_q;

endmodule
